// File: rtl/dot_stream_if.sv
// Handshaked stream bundle for the dot-product engine: beat input side and result output side.
interface dot_stream_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 8,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 8
) ();

  logic                      in_vld;
  logic                      in_rdy;
  logic [LANES*DATA_W-1:0]   in_x;
  logic [LANES*DATA_W-1:0]   in_y;
  logic                      in_last;
  logic                      out_vld;
  logic                      out_rdy;
  logic [ACC_W-1:0]          out_z;
  logic [CNT_W-1:0]          out_cnt;

  // Producer of beats / consumer of results.
  modport master (
    output in_vld, in_x, in_y, in_last, out_rdy,
    input  in_rdy, out_vld, out_z, out_cnt
  );

  // The dot-product engine itself.
  modport slave (
    input  in_vld, in_x, in_y, in_last, out_rdy,
    output in_rdy, out_vld, out_z, out_cnt
  );

endinterface

// File: rtl/dot_stream_acc.sv
// Streaming dot-product engine: per-lane multiply, registered adder tree, and a
// multi-beat accumulator that emits one result (sum and beat count) per vector.
module dot_stream_acc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 8,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  dot_stream_if.slave s
);

  localparam int unsigned LVLS = $clog2(LANES);
  localparam int unsigned PW   = 2 * DATA_W;
  localparam int unsigned TW   = PW + LVLS;
  localparam int unsigned VW   = LANES * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic stall;
  logic take;

  logic                    out_vld_q;
  logic [ACC_W-1:0]        out_z_q;
  logic [CNT_W-1:0]        out_cnt_q;

  // Whole pipeline freezes while a result waits for its consumer.
  assign stall    = out_vld_q && !s.out_rdy;
  assign s.in_rdy = !rst && !stall;
  assign take     = s.in_vld && s.in_rdy;

  assign s.out_vld = out_vld_q;
  assign s.out_z   = out_z_q;
  assign s.out_cnt = out_cnt_q;

  // Input capture stage keeps the multipliers off the input pins.
  logic          in_v_q;
  logic          in_l_q;
  logic [VW-1:0] x_q;
  logic [VW-1:0] y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_q <= 1'b0;
      in_l_q <= 1'b0;
    end else if (!stall) begin
      in_v_q <= take;
      in_l_q <= s.in_last;
      if (take) begin
        x_q <= s.in_x;
        y_q <= s.in_y;
      end
    end
  end

  // Level 0 holds lane products; level k holds pairwise sums grown by k bits.
  for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
    localparam int unsigned N = LANES >> k;
    localparam int unsigned W = PW + k;

    logic signed [W-1:0] sum_q [N];
    logic                vld_q;
    logic                last_q;

    if (k == 0) begin : g_mul
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end else if (!stall) begin
          vld_q  <= in_v_q;
          last_q <= in_l_q;
        end
      end

      for (genvar j = 0; j < N; j++) begin : g_el
        always_ff @(posedge clk) begin
          if (!stall && in_v_q) begin
            sum_q[j] <= W'($signed(x_q[j*DATA_W +: DATA_W])) *
                        W'($signed(y_q[j*DATA_W +: DATA_W]));
          end
        end
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end else if (!stall) begin
          vld_q  <= g_lvl[k-1].vld_q;
          last_q <= g_lvl[k-1].last_q;
        end
      end

      for (genvar j = 0; j < N; j++) begin : g_el
        always_ff @(posedge clk) begin
          if (!stall && g_lvl[k-1].vld_q) begin
            sum_q[j] <= W'(g_lvl[k-1].sum_q[2*j]) + W'(g_lvl[k-1].sum_q[2*j+1]);
          end
        end
      end
    end
  end

  logic signed [TW-1:0]    tsum;
  logic                    tvld;
  logic                    tlast;

  assign tsum  = g_lvl[LVLS].sum_q[0];
  assign tvld  = g_lvl[LVLS].vld_q;
  assign tlast = g_lvl[LVLS].last_q;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sum_ext;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    first_q;

  // Next accumulator and saturating beat count for the beat at the tree output.
  always_comb begin
    sum_ext = ACC_W'(tsum);
    acc_d   = first_q ? sum_ext : acc_q + sum_ext;
    cnt_d   = cnt_q;
    if (first_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      out_vld_q <= 1'b0;
      out_z_q   <= '0;
      out_cnt_q <= '0;
    end else if (!stall) begin
      if (tvld) begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        first_q <= tlast;
      end
      // Not stalled means any held result is consumed on this edge.
      out_vld_q <= tvld && tlast;
      if (tvld && tlast) begin
        out_z_q   <= acc_d;
        out_cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_dot_stream_acc.sv
// Bench for dot_stream_acc: directed scenarios plus randomized traffic, checked every
// cycle against a vector-level reference model with a fixed-latency result queue.
module tb_dot_stream_acc;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LANES  = 8;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned VW     = LANES * DATA_W;
  localparam int          LAT    = $clog2(LANES) + 2;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_stream_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  dot_stream_acc #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  typedef struct { longint z; int cnt; int dly; } pend_t;
  typedef struct { longint z; int cnt; int cyc; } res_t;

  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  bit     chk_en = 1'b0;
  int     vld_cycles = 0;
  int     accept_cyc = 0;

  pend_t  pend[$];
  res_t   model_hist[$];
  res_t   dut_res[$];

  bit     exp_vld = 1'b0;
  longint exp_z = 0;
  int     exp_cnt = 0;
  longint vacc = 0;
  int     vcnt = 0;
  longint bs;
  logic signed [ACC_W-1:0] wz;
  pend_t  pe;
  res_t   re;
  res_t   mr;

  task automatic check(input string nm, input logic signed [63:0] act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: whole-vector sums formed at accept time, released LAT unstalled edges later.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
      exp_vld = 1'b0;
      exp_z   = 0;
      exp_cnt = 0;
      vacc    = 0;
      vcnt    = 0;
    end else if (!(exp_vld && !bus.out_rdy)) begin
      for (int i = 0; i < pend.size(); i++) pend[i].dly--;
      if (pend.size() > 0 && pend[0].dly == 0) begin
        exp_vld = 1'b1;
        exp_z   = pend[0].z;
        exp_cnt = pend[0].cnt;
        re.z = pend[0].z; re.cnt = pend[0].cnt; re.cyc = cyc;
        model_hist.push_back(re);
        void'(pend.pop_front());
      end else begin
        exp_vld = 1'b0;
      end
      if (bus.in_vld) begin
        bs = 0;
        for (int i = 0; i < LANES; i++)
          bs += longint'($signed(bus.in_x[i*DATA_W +: DATA_W])) *
                longint'($signed(bus.in_y[i*DATA_W +: DATA_W]));
        vacc += bs;
        vcnt++;
        if (bus.in_last) begin
          wz = ACC_W'(vacc);
          pe.z   = longint'(wz);
          pe.cnt = (vcnt > CMAX) ? CMAX : vcnt;
          pe.dly = LAT;
          pend.push_back(pe);
          vacc = 0;
          vcnt = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of delivered results.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("in_rdy", 64'(bus.in_rdy), longint'(!rst && !(exp_vld && !bus.out_rdy)));
      check("out_vld", 64'(bus.out_vld), longint'(exp_vld));
      if (exp_vld) begin
        check("out_z", 64'($signed(bus.out_z)), exp_z);
        check("out_cnt", 64'(bus.out_cnt), longint'(exp_cnt));
      end
    end
    if (bus.out_vld === 1'b1) vld_cycles++;
    if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
      mr.z = longint'($signed(bus.out_z)); mr.cnt = int'(bus.out_cnt); mr.cyc = cyc;
      dut_res.push_back(mr);
    end
  end

  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    return r;
  endfunction

  function automatic logic [VW-1:0] lane0(input int v);
    logic [VW-1:0] r;
    r = '0;
    r[DATA_W-1:0] = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom());
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic drive(input logic [VW-1:0] x, input logic [VW-1:0] y, input logic last);
    int  guard;
    logic took;
    guard = 0;
    took  = 1'b0;
    bus.in_x = x; bus.in_y = y; bus.in_last = last; bus.in_vld = 1'b1;
    while (!took && guard < 2000) begin
      @(negedge clk);
      took = bus.in_rdy;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_vld = 1'b0;
    accept_cyc = cyc;
    check("beat_accepted", 64'(took), 1);
  endtask

  task automatic wait_res(input int n, input string nm);
    int g;
    g = 0;
    while (dut_res.size() < n && g < 2000) begin @(posedge clk); #1; g++; end
    check(nm, longint'(dut_res.size()), longint'(n));
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int  base;
  int  v0;
  int  acc1;
  int  g;
  int  len;
  bit  rnd_done;

  initial begin
    bus.in_vld = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_last = 1'b0; bus.out_rdy = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_out_vld", 64'(bus.out_vld), 0);
    check("rst_out_z", 64'($signed(bus.out_z)), 0);
    check("rst_out_cnt", 64'(bus.out_cnt), 0);
    check("rst_in_rdy", 64'(bus.in_rdy), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_rdy", 64'(bus.in_rdy), 1);
    @(posedge clk); #1;

    // 1: single beat, latency and one-cycle result
    base = dut_res.size(); v0 = vld_cycles;
    drive(ramp(), fill(1), 1'b1);
    acc1 = accept_cyc;
    wait_res(base + 1, "s1_count");
    idle(6);
    if (dut_res.size() > base) begin
      check("s1_z", dut_res[base].z, 36);
      check("s1_cnt", 64'(dut_res[base].cnt), 1);
      check("s1_latency", 64'(dut_res[base].cyc - acc1), 5);
    end
    check("s1_vld_cycles", 64'(vld_cycles - v0), 1);

    // 2: three-beat accumulation
    base = dut_res.size();
    for (int b = 0; b < 3; b++) drive(fill(2), fill(3), b == 2);
    wait_res(base + 1, "s2_count");
    idle(8);
    check("s2_single_result", longint'(dut_res.size()), longint'(base + 1));
    if (dut_res.size() > base) begin
      check("s2_z", dut_res[base].z, 144);
      check("s2_cnt", 64'(dut_res[base].cnt), 3);
    end

    // 3: signed extremes
    base = dut_res.size();
    drive(fill(-32768), fill(-32768), 1'b1);
    drive(fill(-32768), fill(32767), 1'b1);
    wait_res(base + 2, "s3_count");
    if (dut_res.size() > base + 1) begin
      check("s3_z_pos", dut_res[base].z, 64'sd8589934592);
      check("s3_z_neg", dut_res[base+1].z, -64'sd8589672448);
    end
    idle(4);
    check("model_hist_n", longint'(model_hist.size()), 4);
    if (model_hist.size() >= 4) begin
      check("model_s1", model_hist[0].z, 36);
      check("model_s2", model_hist[1].z, 144);
      check("model_s2_cnt", 64'(model_hist[1].cnt), 3);
      check("model_s3", model_hist[3].z, -64'sd8589672448);
    end

    // 4: backpressure on the first of two results
    base = dut_res.size();
    drive(ramp(), fill(1), 1'b1);
    drive(fill(1), fill(1), 1'b1);
    g = 0;
    while (bus.out_vld !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
    check("s4_vld_seen", 64'(bus.out_vld), 1);
    bus.out_rdy = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("s4_in_rdy_low", 64'(bus.in_rdy), 0);
      check("s4_z_hold", 64'($signed(bus.out_z)), 36);
    end
    bus.out_rdy = 1'b1;
    wait_res(base + 2, "s4_count");
    idle(8);
    check("s4_no_dup", longint'(dut_res.size()), longint'(base + 2));
    if (dut_res.size() > base + 1) begin
      check("s4_first", dut_res[base].z, 36);
      check("s4_second", dut_res[base+1].z, 8);
    end

    // 5: reset discards a partial vector
    base = dut_res.size();
    drive(fill(1), fill(1), 1'b0);
    drive(fill(1), fill(1), 1'b0);
    reset_pulse();
    check("s5_rst_vld", 64'(bus.out_vld), 0);
    check("s5_rst_z", 64'($signed(bus.out_z)), 0);
    check("s5_rst_cnt", 64'(bus.out_cnt), 0);
    drive(fill(1), fill(1), 1'b1);
    wait_res(base + 1, "s5_count");
    idle(10);
    check("s5_only_one", longint'(dut_res.size()), longint'(base + 1));
    if (dut_res.size() > base) begin
      check("s5_z", dut_res[base].z, 8);
      check("s5_cnt", 64'(dut_res[base].cnt), 1);
    end

    // 6: throughput then count saturation
    base = dut_res.size();
    for (int k = 1; k <= 16; k++) drive(lane0(k), fill(1), 1'b1);
    wait_res(base + 16, "s6_count");
    if (dut_res.size() >= base + 16) begin
      for (int k = 1; k <= 16; k++) begin
        check("s6_z", dut_res[base+k-1].z, longint'(k));
        if (k > 1) check("s6_back_to_back", 64'(dut_res[base+k-1].cyc - dut_res[base+k-2].cyc), 1);
      end
    end
    base = dut_res.size();
    for (int b = 0; b < 300; b++) drive(fill(1), fill(1), b == 299);
    wait_res(base + 1, "s6_sat_count");
    if (dut_res.size() > base) begin
      check("s6_sat_cnt", 64'(dut_res[base].cnt), 255);
      check("s6_sat_z", dut_res[base].z, 2400);
    end
    idle(4);

    // Randomized traffic with random backpressure and one mid-stream reset
    rnd_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 60; v++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            if (v == 30 && b == 1) reset_pulse();
            drive(rnd_vec(), rnd_vec(), b == len - 1);
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_rdy = 1'b1;
    g = 0;
    while ((pend.size() != 0 || exp_vld) && g < 200) begin @(posedge clk); #1; g++; end
    check("drain_done", longint'(pend.size()), 0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
